// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding and enable/flush bundle layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT        = 2'd0,
    ST_RUN         = 2'd1,
    ST_MULDIV_WAIT = 2'd2,
    ST_UNUSED      = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Bit positions inside the enable/flush control bundle
  localparam int CTL_W       = 8;
  localparam int B_PC_EN     = 0;
  localparam int B_IFID_EN   = 1;
  localparam int B_IDEX_EN   = 2;
  localparam int B_EXMEM_EN  = 3;
  localparam int B_MEMWB_EN  = 4;
  localparam int B_IFID_FL   = 5;
  localparam int B_IDEX_FL   = 6;
  localparam int B_EXMEM_FL  = 7;

  typedef logic [CTL_W-1:0] ctl_t;

  function automatic ctl_t ctl_pack(input logic pc_en, input logic ifid_en, input logic idex_en,
                                    input logic exmem_en, input logic memwb_en, input logic ifid_fl,
                                    input logic idex_fl, input logic exmem_fl);
    ctl_t c;
    c             = '0;
    c[B_PC_EN]    = pc_en;
    c[B_IFID_EN]  = ifid_en;
    c[B_IDEX_EN]  = idex_en;
    c[B_EXMEM_EN] = exmem_en;
    c[B_MEMWB_EN] = memwb_en;
    c[B_IFID_FL]  = ifid_fl;
    c[B_IDEX_FL]  = idex_fl;
    c[B_EXMEM_FL] = exmem_fl;
    return c;
  endfunction

  // Canonical output patterns
  localparam ctl_t CTL_RESET   = ctl_pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  localparam ctl_t CTL_INIT    = ctl_pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  localparam ctl_t CTL_FREEZE  = ctl_pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam ctl_t CTL_MULDIV  = ctl_pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  localparam ctl_t CTL_BRANCH  = ctl_pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  localparam ctl_t CTL_LOADUSE = ctl_pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  localparam ctl_t CTL_IMEM    = ctl_pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  localparam ctl_t CTL_ALL     = ctl_pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of pipeline status inputs and stall/flush/counter outputs of the hazard sequencer.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller itself is the backpressure source for the pipeline.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_is_load;
  logic             ex_reg_write_en;
  logic             ex_is_muldiv;
  logic             ex_muldiv_done;
  logic             ex_branch_taken;
  logic             imem_busywait;
  logic             dmem_busywait;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             muldiv_timeout;

  // Pipeline side: reports status, consumes enables/flushes
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr, ex_is_load,
           ex_reg_write_en, ex_is_muldiv, ex_muldiv_done, ex_branch_taken, imem_busywait,
           dmem_busywait,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           ctrl_state, stall_cycles, flush_events, muldiv_timeout
  );

  // Controller side
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr, ex_is_load,
           ex_reg_write_en, ex_is_muldiv, ex_muldiv_done, ex_branch_taken, imem_busywait,
           dmem_busywait,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           ctrl_state, stall_cycles, flush_events, muldiv_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect_unit.sv
// Load-use comparator: flags an ID instruction reading the register a load in EX is about to write.
// Latency: purely combinational.
// Backpressure: none; its output feeds the sequencer's stall decision.
module hazard_detect_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_is_load_i,
  input  logic       ex_reg_write_en_i,
  output logic       load_use_stall_o
);

  // x0 never carries a dependency, so a load targeting it cannot cause a stall
  always_comb begin
    load_use_stall_o = 1'b0;
    if (ex_is_load_i && ex_reg_write_en_i && (ex_rd_addr_i != REG_X0)) begin
      load_use_stall_o = (id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                         (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i));
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with post-reset purge, mul/div wait and counters.
// Latency: enables/flushes are combinational from state and inputs; counters/flags update next edge.
// Backpressure: drops per-stage enables on memory busywait, mul/div, load-use and fetch stalls.
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES       = 5,
  parameter int MULDIV_MAX_CYCLES = 40,
  parameter int CNT_W             = 32
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave hif
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WCW = (MULDIV_MAX_CYCLES > 1) ? $clog2(MULDIV_MAX_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MULDIV_MAX_CYCLES - 1);

  ctrl_state_e      state_q, state_d;
  logic [ICW-1:0]   init_cnt_q, init_cnt_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  ctl_t             ctl;
  logic             flush_evt;
  logic             load_use_stall;

  hazard_detect_unit u_hdu (
    .id_rs1_addr_i     (hif.id_rs1_addr),
    .id_rs2_addr_i     (hif.id_rs2_addr),
    .id_uses_rs1_i     (hif.id_uses_rs1),
    .id_uses_rs2_i     (hif.id_uses_rs2),
    .ex_rd_addr_i      (hif.ex_rd_addr),
    .ex_is_load_i      (hif.ex_is_load),
    .ex_reg_write_en_i (hif.ex_reg_write_en),
    .load_use_stall_o  (load_use_stall)
  );

  // Next-state, stall/flush pattern and counter update; reset forces the purge pattern at once
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    ctl        = CTL_ALL;
    flush_evt  = 1'b0;

    case (state_q)
      ST_INIT: begin
        ctl        = CTL_INIT;
        init_cnt_d = init_cnt_q + ICW'(1);
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end

      ST_MULDIV_WAIT: begin
        if (hif.dmem_busywait) begin
          // Full freeze; the wait counter deliberately holds so memory stalls do not eat the budget
          ctl = CTL_FREEZE;
        end else if (hif.ex_muldiv_done) begin
          ctl     = CTL_ALL;
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          // Watchdog: push the stuck op out rather than hang the core
          ctl       = CTL_ALL;
          timeout_d = 1'b1;
          state_d   = ST_RUN;
          wait_d    = '0;
        end else begin
          ctl    = CTL_MULDIV;
          wait_d = wait_q + WCW'(1);
        end
      end

      default: begin
        // RUN, and the unused encoding which recovers into RUN
        state_d = ST_RUN;
        if (hif.dmem_busywait) begin
          ctl = CTL_FREEZE;
        end else if (hif.ex_is_muldiv && !hif.ex_muldiv_done) begin
          ctl     = CTL_MULDIV;
          state_d = ST_MULDIV_WAIT;
          wait_d  = '0;
        end else if (hif.ex_branch_taken) begin
          // Redirect wins over load-use and fetch stalls: both younger instructions are squashed
          ctl       = CTL_BRANCH;
          flush_evt = 1'b1;
        end else if (load_use_stall) begin
          ctl = CTL_LOADUSE;
        end else if (hif.imem_busywait) begin
          ctl = CTL_IMEM;
        end
      end
    endcase

    if ((state_q != ST_INIT) && !ctl[B_PC_EN] && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_evt && !(&flush_q)) begin
      flush_d = flush_q + CNT_W'(1);
    end

    if (!reset) begin
      ctl = CTL_RESET;
    end
  end

  // State, counters and sticky watchdog flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_q     <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hif.pc_en          = ctl[B_PC_EN];
  assign hif.ifid_en        = ctl[B_IFID_EN];
  assign hif.idex_en        = ctl[B_IDEX_EN];
  assign hif.exmem_en       = ctl[B_EXMEM_EN];
  assign hif.memwb_en       = ctl[B_MEMWB_EN];
  assign hif.ifid_flush     = ctl[B_IFID_FL];
  assign hif.idex_flush     = ctl[B_IDEX_FL];
  assign hif.exmem_flush    = ctl[B_EXMEM_FL];
  assign hif.ctrl_state     = state_q;
  assign hif.stall_cycles   = stall_q;
  assign hif.flush_events   = flush_q;
  assign hif.muldiv_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for the hazard sequencer: driver predicts each cycle's response, monitor compares.
// Latency: expected outputs are checked on the falling edge of the cycle they were predicted for.
// Backpressure: n/a.
module tb_pipeline_hazard_controller;

  localparam int INIT_CYCLES = 5;
  localparam int MAXC        = 40;
  localparam int CNT_W       = 6;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  // Which rule the reference model applied in the current cycle
  localparam int R_RESET = 0, R_INIT = 1, R_FREEZE = 2, R_MUL_ENTER = 3, R_BRANCH = 4,
                 R_LU = 5, R_IMEM = 6, R_NORMAL = 7, R_MUL_HOLD = 8, R_MUL_DONE = 9,
                 R_MUL_TO = 10;

  typedef struct {
    logic [7:0] ctl;   // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush}
    int         st;
    longint     stall;
    longint     flush;
    bit         to;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hif ();

  pipeline_hazard_controller #(
    .INIT_CYCLES(INIT_CYCLES), .MULDIV_MAX_CYCLES(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hif  (hif)
  );

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     mon_cyc  = 0;

  // Reference model state (behavioural view of the sequencer)
  int     m_phase;       // 0 purge, 1 running, 2 waiting on mul/div
  int     m_init_edges;
  int     m_mul_stalls;  // stalled cycles spent on the current mul/div, entry cycle included
  longint m_stall, m_flush;
  bit     m_to;
  int     m_rule;

  function automatic void model_reset();
    m_phase = 0; m_init_edges = 0; m_mul_stalls = 0;
    m_stall = 0; m_flush = 0; m_to = 1'b0;
  endfunction

  function automatic logic [7:0] pk(bit pc, bit ifid, bit idex, bit exmem, bit memwb,
                                    bit fi, bit fd, bit fe);
    return {pc, ifid, idex, exmem, memwb, fi, fd, fe};
  endfunction

  function automatic bit load_use();
    if (!hif.ex_is_load || !hif.ex_reg_write_en || hif.ex_rd_addr == 5'd0) return 1'b0;
    return (hif.id_uses_rs1 && hif.id_rs1_addr == hif.ex_rd_addr) ||
           (hif.id_uses_rs2 && hif.id_rs2_addr == hif.ex_rd_addr);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.st = m_phase; e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    if (!reset) begin
      e.ctl = pk(0,0,0,0,0,1,1,1); m_rule = R_RESET;
    end else if (m_phase == 0) begin
      e.ctl = pk(1,1,1,1,1,1,1,1); m_rule = R_INIT;
    end else if (hif.dmem_busywait) begin
      e.ctl = pk(0,0,0,0,0,0,0,0); m_rule = R_FREEZE;
    end else if (m_phase == 2) begin
      if (hif.ex_muldiv_done) begin
        e.ctl = pk(1,1,1,1,1,0,0,0); m_rule = R_MUL_DONE;
      end else if (m_mul_stalls == MAXC) begin
        e.ctl = pk(1,1,1,1,1,0,0,0); m_rule = R_MUL_TO;
      end else begin
        e.ctl = pk(0,0,0,1,1,0,0,1); m_rule = R_MUL_HOLD;
      end
    end else if (hif.ex_is_muldiv && !hif.ex_muldiv_done) begin
      e.ctl = pk(0,0,0,1,1,0,0,1); m_rule = R_MUL_ENTER;
    end else if (hif.ex_branch_taken) begin
      e.ctl = pk(1,1,1,1,1,1,1,0); m_rule = R_BRANCH;
    end else if (load_use()) begin
      e.ctl = pk(0,0,1,1,1,0,1,0); m_rule = R_LU;
    end else if (hif.imem_busywait) begin
      e.ctl = pk(0,1,1,1,1,1,0,0); m_rule = R_IMEM;
    end else begin
      e.ctl = pk(1,1,1,1,1,0,0,0); m_rule = R_NORMAL;
    end
    return e;
  endfunction

  function automatic void model_update(exp_t e);
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_rule != R_INIT && m_rule != R_RESET && !e.ctl[7] && m_stall < CNT_MAX) m_stall++;
    case (m_rule)
      R_INIT:      begin m_init_edges++; if (m_init_edges == INIT_CYCLES) m_phase = 1; end
      R_BRANCH:    if (m_flush < CNT_MAX) m_flush++;
      R_MUL_ENTER: begin m_phase = 2; m_mul_stalls = 1; end
      R_MUL_HOLD:  m_mul_stalls++;
      R_MUL_DONE:  m_phase = 1;
      R_MUL_TO:    begin m_phase = 1; m_to = 1'b1; end
      default:     ;
    endcase
  endfunction

  // One clock of stimulus: inputs are already applied; predict, queue, advance, update model
  task automatic step();
    exp_t e;
    if (!reset) model_reset();
    e = predict();
    sb.push_back(e);
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_idle();
    hif.id_rs1_addr = 5'd0; hif.id_rs2_addr = 5'd0;
    hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.ex_rd_addr = 5'd0; hif.ex_is_load = 1'b0; hif.ex_reg_write_en = 1'b0;
    hif.ex_is_muldiv = 1'b0; hif.ex_muldiv_done = 1'b0; hif.ex_branch_taken = 1'b0;
    hif.imem_busywait = 1'b0; hif.dmem_busywait = 1'b0;
  endtask

  task automatic rand_inputs();
    hif.id_rs1_addr     = 5'($urandom_range(0, 3));
    hif.id_rs2_addr     = 5'($urandom_range(0, 3));
    hif.id_uses_rs1     = ($urandom_range(0, 1) == 1);
    hif.id_uses_rs2     = ($urandom_range(0, 1) == 1);
    hif.ex_rd_addr      = 5'($urandom_range(0, 3));
    hif.ex_is_load      = ($urandom_range(0, 2) == 0);
    hif.ex_reg_write_en = ($urandom_range(0, 3) != 0);
    hif.ex_is_muldiv    = ($urandom_range(0, 9) == 0);
    hif.ex_muldiv_done  = ($urandom_range(0, 3) == 0);
    hif.ex_branch_taken = ($urandom_range(0, 5) == 0);
    hif.imem_busywait   = ($urandom_range(0, 3) == 0);
    hif.dmem_busywait   = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at monitor cycle %0d: got 0x%0h, expected 0x%0h", name, mon_cyc, act, exp);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare it against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ctl_bundle", {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                           hif.ifid_flush, hif.idex_flush, hif.exmem_flush}, e.ctl);
      check("ctrl_state", hif.ctrl_state, e.st);
      check("stall_cycles", hif.stall_cycles, e.stall);
      check("flush_events", hif.flush_events, e.flush);
      check("muldiv_timeout", hif.muldiv_timeout, e.to);
      mon_cyc++;
    end
  end

  initial begin
    reset = 1'b0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;

    // Reset held, then release into the purge sequence and RUN
    steps(3);
    reset = 1'b1;
    steps(8);

    // Load-use on rs2, then the same with rd=x0
    hif.ex_is_load = 1'b1; hif.ex_reg_write_en = 1'b1; hif.ex_rd_addr = 5'd5;
    hif.id_rs2_addr = 5'd5; hif.id_uses_rs2 = 1'b1;
    step();
    set_idle();
    step();
    hif.ex_is_load = 1'b1; hif.ex_reg_write_en = 1'b1; hif.ex_rd_addr = 5'd0;
    hif.id_rs2_addr = 5'd0; hif.id_uses_rs2 = 1'b1;
    step();
    set_idle();
    step();

    // MUL completing after 33 stalled cycles
    hif.ex_is_muldiv = 1'b1;
    steps(33);
    hif.ex_muldiv_done = 1'b1;
    step();
    set_idle();
    steps(2);

    // Branch + load-use + fetch stall in one cycle
    hif.ex_branch_taken = 1'b1; hif.imem_busywait = 1'b1;
    hif.ex_is_load = 1'b1; hif.ex_reg_write_en = 1'b1; hif.ex_rd_addr = 5'd7;
    hif.id_rs1_addr = 5'd7; hif.id_uses_rs1 = 1'b1;
    step();
    set_idle();
    step();

    // DIV that never completes: watchdog fires, flag stays set
    hif.ex_is_muldiv = 1'b1;
    steps(MAXC + 1);
    set_idle();
    steps(5);

    // Reset mid-operation, then a mul/div wait interrupted by a 4-cycle memory freeze
    reset = 1'b0;
    step();
    reset = 1'b1;
    steps(INIT_CYCLES + 1);
    hif.ex_is_muldiv = 1'b1;
    steps(10);
    hif.dmem_busywait = 1'b1;
    steps(4);
    hif.dmem_busywait = 1'b0;
    steps(MAXC - 10 + 1);
    set_idle();
    steps(3);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 299) != 0);
      step();
    end
    reset = 1'b1;
    set_idle();
    steps(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives the enable and flush inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Causes it handles: data-memory busywait, multicycle mul/div, taken branches/jumps, load-use hazards, instruction-memory busywait, and the post-reset pipeline purge. It also keeps stall/flush performance counters and a sticky mul/div watchdog flag.

Parameters:
INIT_CYCLES, 5, cycles after reset release during which every pipeline register is flushed.
MULDIV_MAX_CYCLES, 40, cycles a mul/div may sit in MULDIV_WAIT before the watchdog forces advance.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
id_rs1_addr  in  5  rs1 of the instruction in ID.
id_rs2_addr  in  5  rs2 of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_rd_addr  in  5  destination register of the instruction in EX.
ex_is_load  in  1  EX instruction is a load.
ex_reg_write_en  in  1  EX instruction writes the register file.
ex_is_muldiv  in  1  EX instruction is an M-extension op.
ex_muldiv_done  in  1  mul/div result is valid this cycle.
ex_branch_taken  in  1  EX redirects the PC.
imem_busywait  in  1  instruction memory is not ready.
dmem_busywait  in  1  data memory is not ready.
pc_en  out  1  PC update enable.
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
ifid_flush, idex_flush, exmem_flush  out  1 each  load a NOP/bubble (all control bits 0) instead of the input.
ctrl_state  out  2  current FSM state.
stall_cycles  out  CNT_W  cycles with pc_en=0 in RUN or MULDIV_WAIT.
flush_events  out  CNT_W  taken-branch flushes.
muldiv_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset asserted (reset=0): immediately, all *_en=0, all *_flush=1, state=INIT, counters=0, muldiv_timeout=0, init counter=0.
- INIT: outputs as in reset except all *_en=1, so the bubbles propagate. Leave to RUN after INIT_CYCLES rising edges.
- RUN: the first matching rule applies each cycle; the outputs are combinational from state plus inputs.
  1. dmem_busywait=1: all en=0, all flush=0 (full freeze).
  2. ex_is_muldiv=1 and ex_muldiv_done=0: pc_en=ifid_en=idex_en=0, exmem_en=1, exmem_flush=1, memwb_en=1. Next state MULDIV_WAIT.
  3. ex_branch_taken=1: all en=1, ifid_flush=1, idex_flush=1. flush_events+1. Overrides the load-use stall and imem_busywait; the PC takes the target even if a fetch is in progress.
  4. Load-use: ex_is_load and ex_reg_write_en and ex_rd_addr!=0, and either (id_uses_rs1 and rs1==rd) or (id_uses_rs2 and rs2==rd). Then pc_en=ifid_en=0, idex_en=1, idex_flush=1, rest en=1. This is exactly one bubble, because the load leaves EX next cycle.
  5. imem_busywait=1: pc_en=0, ifid_en=1, ifid_flush=1, rest en=1.
  6. Otherwise all en=1, all flush=0.
- MULDIV_WAIT: the outputs from rule 2 are held while a wait counter increments.
  - dmem_busywait=1 overrides to full freeze and the wait counter holds.
  - ex_muldiv_done=1: all en=1 that cycle (result captured into EX/MEM); return to RUN and clear the counter.
  - Counter reaches MULDIV_MAX_CYCLES-1 without done: set muldiv_timeout, force the all-en=1 advance, return to RUN.
- Counters: stall_cycles increments whenever pc_en=0 in RUN or MULDIV_WAIT, including dmem freezes. Both counters saturate at all-ones.
- Reset mid-operation: asynchronous return to INIT from any state. Outputs switch immediately to the reset values.
- ctrl_state encoding: INIT=0, RUN=1, MULDIV_WAIT=2, 3 unused (decodes as RUN-safe: go to RUN).

Decomposition:
- Package hazard_ctrl_pkg: state encoding, the enable/flush bundle bit positions, and REG_X0=5'd0.
- Sub-module hazard_detect_unit: purely combinational load-use comparator producing load_use_stall. This lets the comparator be verified exhaustively on its own.

Test Plan:
- Reset low for 3 cycles, then release → all flush=1 and en=0 during reset; flush=1 with en=1 for 5 cycles; state=RUN at cycle 6.
- Load in EX with rd=5, ID rs2=5, id_uses_rs2=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1. Repeat with rd=0 → no stall.
- MUL in EX with done raised after 33 cycles → 33 cycles of the rule-2 pattern, then one all-en cycle; stall_cycles=33; muldiv_timeout=0.
- DIV with done never asserted → forced advance after 40 cycles; muldiv_timeout=1, remaining set until reset.
- Branch taken, load-use and imem_busywait all in the same cycle → ifid_flush=idex_flush=1, pc_en=1, flush_events incremented by 1.
- dmem_busywait held for 4 cycles during MULDIV_WAIT → all en=0 for 4 cycles; the wait counter is unchanged across the freeze.
